sha256_message_padder: RTL and testbench
========================================

Name: sha256_message_padder

Overview:
- Upstream stage of sha256_hash_compression.
- Accepts a byte-oriented message as a stream of 32-bit big-endian words.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit bit-length.
- Emits 512-bit blocks with a last flag on the same valid/ready/last handshake the compression stage consumes.

Parameters:
- None. The block is fixed to SHA-256: 32-bit input beats, 512-bit blocks, 64-bit length field.

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
en  input  1  clock enable; state held while low
sync_rst  input  1  synchronous localised reset; priority over en
data_in  input  32  message word; first byte in [31:24]
data_in_nbytes  input  3  valid bytes in the last beat (0..4); ignored on non-last beats
data_in_last  input  1  final beat of the message
data_in_valid  input  1  input beat valid
data_in_ready  output  1  input beat accepted when valid&ready
data_out  output  512  padded block; word 0 in [511:480]
data_out_last  output  1  final block of the message
data_out_valid  output  1  block valid
data_out_ready  input  1  downstream accepts the block

Behaviour:
- Reset is clk/nrst: reset nrst, asynchronous, active-low; clock clk. sync_rst does the same on a clock edge.
- Values under reset:
  - data_in_ready=0, data_out_valid=0, data_out_last=0, data_out=0.
  - State=COLLECT; word index widx=0; 64-bit length counter len=0; block buffer cleared.
  - data_in_ready rises the first enabled cycle after reset.
- en=0: all registers hold. data_in_ready and data_out_valid are gated to 0, so no handshake completes. Registered values reappear when en returns.
- State COLLECT (data_in_ready=1, data_out_valid=0):
  - Non-last beat: buf[widx]=data_in; len+=32; widx++.
  - widx==15 non-last beat: load data_out={buf,word}, data_out_last=0, then go to OUT_BLOCK.
  - Last beat, with n=min(data_in_nbytes,4):
    - Word w=widx gets bytes 0..n-1 from data_in. If n<4, byte n=0x80 and the remaining bytes are 0. len+=8n.
    - The pad byte sits in word w (n<4), in word w+1 byte0 (n==4, w<15), or in the next block's word0 (n==4, w==15).
    - Let p = index of the first word after the pad byte.
    - p<=14: single final block. Words p..13 are 0; words 14..15 hold the final len; data_out_last=1.
    - Otherwise: this block is zero-filled after the pad byte with data_out_last=0, and extra_pend is set. The extra block has words 0..13 zero (word0=0x80000000 if the pad byte was deferred), words 14..15 hold len, and data_out_last=1.
  - data_out_valid rises the cycle after the completing beat. data_in_ready falls in that same cycle.
- State OUT_BLOCK (data_in_ready=0, data_out_valid=1):
  - data_out and data_out_last are held stable until data_out_ready.
  - On handshake with extra_pend=1: the extra block is loaded into data_out the next cycle, valid stays 1, extra_pend clears.
  - On handshake with extra_pend=0: valid drops next cycle, then return to COLLECT with data_in_ready=1. widx is cleared. If the block just sent was last, len is also cleared.
- The length counter wraps modulo 2^64. Messages longer than 2^64-1 bits are outside the supported range.
- A zero-length message is a single last beat with nbytes=0.
- At most one beat is accepted per cycle. Input is never accepted while an output block is pending, so simultaneous in/out handshakes cannot occur.
- Reset mid-message discards the partial block and len. No block is emitted for the discarded data.
- Throughput:
  - 16 input cycles plus 1 output cycle per full block, with no backpressure.
  - Each extra padding block costs one more output handshake.

Test Plan:
- "abc": one beat 0x61626300, nbytes=3, last → one block: word0=0x61626380, words1..14=0, word15=0x00000018, last=1. Chained into compression, the digest is ba7816bf...f20015ad.
- Empty message: one beat, nbytes=0, last → block word0=0x80000000, all other words 0, last=1.
- 56 bytes: 14 full beats, last on beat 14 with nbytes=4 → block1 has data words0..13, word14=0x80000000, word15=0, last=0. Block2 has words0..14=0, word15=0x000001C0, last=1.
- 64 bytes: 16 full beats, last with nbytes=4 → block1 is pure data with last=0. Block2 has word0=0x80000000, word15=0x00000200, last=1. No extra beat is accepted between the two blocks.
- Backpressure and en: hold data_out_ready=0 for 5 cycles → data_out is bit-stable and data_in_ready=0 throughout. Pulse en=0 for 3 cycles mid-collect → no beat is accepted and the resulting block is unchanged.
- Reset mid-message: assert sync_rst after 7 beats, then send "abc" → output exactly matches the "abc" block; len=0x18 proves the counter was cleared.

Source files
------------

// File: rtl/sha256_message_padder_if.sv
// Word-stream in / 512-bit block out handshake bundle between a message source,
// the SHA-256 padder and the compression stage.
interface sha256_message_padder_if;
    logic [31:0]  data_in;
    logic [2:0]   data_in_nbytes;
    logic         data_in_last;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [511:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;

    modport master (
        output data_in, data_in_nbytes, data_in_last, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_last, data_out_valid
    );

    modport slave (
        input  data_in, data_in_nbytes, data_in_last, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_last, data_out_valid
    );
endinterface

// File: rtl/sha256_message_padder.sv
// SHA-256 message padder: packs big-endian 32-bit beats into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit bit-length, spilling into an extra block if needed.
module sha256_message_padder (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   sync_rst,
    sha256_message_padder_if.slave bus
);
    typedef enum logic {COLLECT, OUT_BLOCK} state_t;

    state_t       state_q, state_d;
    logic [31:0]  word_buf_q [15];
    logic [31:0]  word_buf_d [15];
    logic [3:0]   widx_q, widx_d;
    logic [63:0]  len_q, len_d;
    logic         rdy_q, rdy_d;
    logic         vld_q, vld_d;
    logic         last_q, last_d;
    logic         extra_q, extra_d;
    logic         defer_q, defer_d;
    logic [511:0] out_q, out_d;

    logic         in_fire;
    logic         out_fire;
    logic [2:0]   nb;
    logic [31:0]  beat_word;
    logic [63:0]  len_next;
    logic [4:0]   pad_end;
    logic         final_here;
    logic         completes;
    logic [511:0] final_blk;
    logic [511:0] extra_blk;
    logic [31:0]  blk_word;
    logic [3:0]   wi;

    assign bus.data_in_ready  = rdy_q & en;
    assign bus.data_out_valid = vld_q & en;
    assign bus.data_out       = out_q;
    assign bus.data_out_last  = last_q;

    assign in_fire  = bus.data_in_valid & bus.data_in_ready;
    assign out_fire = bus.data_out_valid & bus.data_out_ready;

    // Beat decode: byte masking plus pad byte on the last beat, and where padding ends.
    always_comb begin
        nb        = (bus.data_in_nbytes > 3'd4) ? 3'd4 : bus.data_in_nbytes;
        beat_word = bus.data_in;
        if (bus.data_in_last) begin
            case (nb)
                3'd0:    beat_word = 32'h8000_0000;
                3'd1:    beat_word = {bus.data_in[31:24], 24'h80_0000};
                3'd2:    beat_word = {bus.data_in[31:16], 16'h8000};
                3'd3:    beat_word = {bus.data_in[31:8], 8'h80};
                default: beat_word = bus.data_in;
            endcase
        end
        len_next   = len_q + (bus.data_in_last ? {58'd0, nb, 3'd0} : 64'd32);
        pad_end    = {1'b0, widx_q} + ((bus.data_in_last && nb == 3'd4) ? 5'd2 : 5'd1);
        final_here = bus.data_in_last && (pad_end <= 5'd14);
        completes  = bus.data_in_last || (widx_q == 4'd15);
    end

    // Block assembled from the buffered words plus the beat arriving this cycle.
    always_comb begin
        final_blk = '0;
        blk_word  = '0;
        wi        = '0;
        for (int i = 0; i < 16; i++) begin
            wi = 4'(i);
            if (wi < widx_q)
                blk_word = word_buf_q[wi];
            else if (wi == widx_q)
                blk_word = beat_word;
            else if (bus.data_in_last && nb == 3'd4 && wi == widx_q + 4'd1)
                blk_word = 32'h8000_0000;
            else
                blk_word = '0;
            if (final_here && wi == 4'd14) blk_word = len_next[63:32];
            if (final_here && wi == 4'd15) blk_word = len_next[31:0];
            final_blk[511 - 32*i -: 32] = blk_word;
        end
    end

    // A full last block defers the 0x80 marker into word 0 of the extra block.
    assign extra_blk = {(defer_q ? 32'h8000_0000 : 32'h0000_0000), 416'd0, len_q};

    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        word_buf_d = word_buf_q;
        widx_d     = widx_q;
        len_d      = len_q;
        rdy_d      = rdy_q;
        vld_d      = vld_q;
        last_d     = last_q;
        extra_d    = extra_q;
        defer_d    = defer_q;
        out_d      = out_q;

        case (state_q)
            COLLECT: begin
                rdy_d = 1'b1;
                if (in_fire) begin
                    len_d = len_next;
                    if (completes) begin
                        out_d   = final_blk;
                        last_d  = final_here;
                        extra_d = bus.data_in_last && !final_here;
                        defer_d = bus.data_in_last && nb == 3'd4 && widx_q == 4'd15;
                        rdy_d   = 1'b0;
                        vld_d   = 1'b1;
                        state_d = OUT_BLOCK;
                    end else begin
                        word_buf_d[widx_q] = bus.data_in;
                        widx_d             = widx_q + 4'd1;
                    end
                end
            end
            OUT_BLOCK: begin
                if (out_fire) begin
                    if (extra_q) begin
                        out_d   = extra_blk;
                        last_d  = 1'b1;
                        extra_d = 1'b0;
                        defer_d = 1'b0;
                    end else begin
                        vld_d   = 1'b0;
                        rdy_d   = 1'b1;
                        widx_d  = '0;
                        state_d = COLLECT;
                        if (last_q) len_d = '0;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= COLLECT;
            widx_q  <= '0;
            len_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            defer_q <= 1'b0;
            out_q   <= '0;
            // NOTE: the word buffer is flop-based and small, so it is cleared like any other register.
            for (int i = 0; i < 15; i++) word_buf_q[i] <= '0;
        end else if (sync_rst) begin
            state_q <= COLLECT;
            widx_q  <= '0;
            len_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            defer_q <= 1'b0;
            out_q   <= '0;
            for (int i = 0; i < 15; i++) word_buf_q[i] <= '0;
        end else if (en) begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            len_q      <= len_d;
            rdy_q      <= rdy_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            extra_q    <= extra_d;
            defer_q    <= defer_d;
            out_q      <= out_d;
            word_buf_q <= word_buf_d;
        end
    end
endmodule

// File: tb/tb_sha256_message_padder.sv
// Bench for sha256_message_padder: byte-level padding model feeding a block scoreboard,
// a table of message lengths, and hand sequences for backpressure, en gaps and sync_rst.
module tb_sha256_message_padder;
    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    typedef struct {
        int len;
        bit bump;
        int exp_blocks;
    } vec_t;

    logic clk;
    logic nrst;
    logic en;
    logic sync_rst;

    sha256_message_padder_if bus ();

    sha256_message_padder dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .sync_rst (sync_rst),
        .bus      (bus)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          blk_cnt = 0;
    logic [31:0] last_word = '0;
    blk_t        exp_q [$];
    blk_t        mon_e;
    logic [7:0]  msg_bytes [256];
    vec_t        vecs [15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Scoreboard: each output handshake pops one expected block.
    always @(negedge clk) begin
        if (bus.data_out_valid) begin
            check("in_ready_during_out", 512'(bus.data_in_ready), 512'(0));
            if (bus.data_out_ready) begin
                blk_cnt++;
                last_word = bus.data_out[31:0];
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_block: got %0h expected none", bus.data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("block_data", bus.data_out, mon_e.data);
                    check("block_last", 512'(bus.data_out_last), 512'(mon_e.last));
                end
            end
        end
    end

    // Reference: textbook byte-wise padding of msg_bytes[0..len-1].
    task automatic push_model(input int len);
        logic [7:0]  p [$];
        logic [63:0] bits;
        blk_t        b;
        int          nblk;
        bits = 64'(len) << 3;
        for (int i = 0; i < len; i++) p.push_back(msg_bytes[i]);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data[511 - 8*j -: 8] = p[64*k + j];
            b.last = (k == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int cyc;
        cyc = 0;
        bus.data_in        = d;
        bus.data_in_nbytes = nb;
        bus.data_in_last   = last;
        bus.data_in_valid  = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.data_in_ready) break;
            cyc++;
            if (cyc > 200) begin
                fail_bound("input_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
    endtask

    task automatic send_msg(input int len, input bit bump, input int gap_at);
        int          nbeats;
        logic [31:0] d;
        logic [2:0]  nb;
        logic        is_last;
        nbeats = (len == 0) ? 1 : (len + 3) / 4;
        for (int b = 0; b < nbeats; b++) begin
            d = 32'hAAAA_AAAA;
            for (int k = 0; k < 4; k++)
                if (4*b + k < len) d[31 - 8*k -: 8] = msg_bytes[4*b + k];
            is_last = (b == nbeats - 1);
            if (!is_last)        nb = 3'(b);
            else if (len == 0)   nb = 3'd0;
            else if (len % 4 == 0) nb = bump ? 3'd7 : 3'd4;
            else                 nb = 3'(len % 4);
            if (b == gap_at) begin
                en                 = 1'b0;
                bus.data_in        = d;
                bus.data_in_nbytes = nb;
                bus.data_in_last   = is_last;
                bus.data_in_valid  = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("ready_gated_by_en", 512'(bus.data_in_ready), 512'(0));
                end
                @(posedge clk);
                #1;
                en = 1'b1;
            end
            send_beat(d, nb, is_last);
        end
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.data_out_valid) && cyc < 300) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (exp_q.size() != 0 || bus.data_out_valid) fail_bound(name);
    endtask

    task automatic fill_msg(input int seed);
        for (int i = 0; i < 256; i++) msg_bytes[i] = 8'((i * 37 + seed * 11 + 5) & 255);
    endtask

    initial begin
        blk_t        b;
        int          start;
        int          cyc;
        logic [511:0] held;

        vecs[0]  = '{0,   1'b0, 1};
        vecs[1]  = '{3,   1'b0, 1};
        vecs[2]  = '{4,   1'b0, 1};
        vecs[3]  = '{5,   1'b0, 1};
        vecs[4]  = '{55,  1'b0, 1};
        vecs[5]  = '{56,  1'b0, 2};
        vecs[6]  = '{57,  1'b0, 2};
        vecs[7]  = '{60,  1'b0, 2};
        vecs[8]  = '{63,  1'b0, 2};
        vecs[9]  = '{64,  1'b0, 2};
        vecs[10] = '{65,  1'b0, 2};
        vecs[11] = '{119, 1'b0, 2};
        vecs[12] = '{120, 1'b0, 3};
        vecs[13] = '{128, 1'b0, 3};
        vecs[14] = '{8,   1'b1, 1};

        nrst               = 1'b0;
        en                 = 1'b1;
        sync_rst           = 1'b0;
        bus.data_in        = '0;
        bus.data_in_nbytes = '0;
        bus.data_in_last   = 1'b0;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;

        #3;
        check("rst_in_ready", 512'(bus.data_in_ready), 512'(0));
        check("rst_out_valid", 512'(bus.data_out_valid), 512'(0));
        check("rst_out_last", 512'(bus.data_out_last), 512'(0));
        check("rst_data_out", bus.data_out, 512'(0));
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 512'(bus.data_in_ready), 512'(1));

        // "abc"
        start  = blk_cnt;
        b.data = {32'h6162_6380, 448'd0, 32'h0000_0018};
        b.last = 1'b1;
        exp_q.push_back(b);
        send_beat(32'h6162_6300, 3'd3, 1'b1);
        drain("drain_abc");
        check("abc_nblocks", 512'(blk_cnt - start), 512'(1));

        // empty message
        start  = blk_cnt;
        b.data = {32'h8000_0000, 480'd0};
        b.last = 1'b1;
        exp_q.push_back(b);
        send_beat(32'h1234_5678, 3'd0, 1'b1);
        drain("drain_empty");
        check("empty_nblocks", 512'(blk_cnt - start), 512'(1));

        for (int r = 0; r < 15; r++) begin
            fill_msg(r);
            start = blk_cnt;
            push_model(vecs[r].len);
            send_msg(vecs[r].len, vecs[r].bump, -1);
            drain("drain_vec");
            check("vec_nblocks", 512'(blk_cnt - start), 512'(vecs[r].exp_blocks));
            check("vec_len_field", 512'(last_word), 512'(32'(vecs[r].len * 8)));
        end

        // backpressure: block must stay bit-stable while the sink stalls
        fill_msg(40);
        start = blk_cnt;
        bus.data_out_ready = 1'b0;
        push_model(10);
        send_msg(10, 1'b0, -1);
        cyc = 0;
        while (!bus.data_out_valid && cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (!bus.data_out_valid) fail_bound("bp_valid");
        held = bus.data_out;
        repeat (5) begin
            @(negedge clk);
            check("bp_data_stable", bus.data_out, held);
            check("bp_in_ready", 512'(bus.data_in_ready), 512'(0));
        end
        bus.data_out_ready = 1'b1;
        drain("drain_bp");
        check("bp_nblocks", 512'(blk_cnt - start), 512'(1));

        // en gap mid-collect
        fill_msg(41);
        start = blk_cnt;
        push_model(30);
        send_msg(30, 1'b0, 3);
        drain("drain_en_gap");
        check("en_gap_nblocks", 512'(blk_cnt - start), 512'(1));

        // sync_rst after 7 beats discards the partial message and its length
        fill_msg(42);
        start = blk_cnt;
        for (int i = 0; i < 7; i++)
            send_beat({msg_bytes[4*i], msg_bytes[4*i+1], msg_bytes[4*i+2], msg_bytes[4*i+3]}, 3'd0, 1'b0);
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        check("ready_after_sync_rst", 512'(bus.data_in_ready), 512'(0));
        b.data = {32'h6162_6380, 448'd0, 32'h0000_0018};
        b.last = 1'b1;
        exp_q.push_back(b);
        send_beat(32'h6162_6300, 3'd3, 1'b1);
        drain("drain_sync_rst");
        check("sync_rst_nblocks", 512'(blk_cnt - start), 512'(1));
        check("sync_rst_len", 512'(last_word), 512'(32'h18));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
